reglk_ctrl: RTL and testbench

Parametrised register-lock controller: holds NUM_REGS lock words that gate writes to protected peripheral registers, and owns the only path by which lock bits may be cleared. It is the successor to the fixed six-entry lock bank. Lock clearing (software lock-reset or lowering bits) is permitted only after a successful JTAG key unlock. An attempt counter and timed lockout prevent brute-forcing the key. It sits between the SoC register bus and the peripheral write-enable logic.

---
 rtl/reglk_pkg.sv | 28 ++
 rtl/reglk_unlock_fsm.sv | 97 +++++++++
 rtl/reglk_ctrl.sv | 90 +++++++++
 tb/tb_reglk_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reglk_pkg.sv
// Shared types and sizing helpers for the register-lock controller.
package reglk_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } reglk_state_e;

    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_MAX_ATTEMPTS   = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 1024;
    localparam logic [DEF_DATA_W-1:0] DEF_RST_VAL = '1;

    function automatic int unsigned att_cnt_w(input int unsigned max_attempts);
        return $clog2(max_attempts + 1);
    endfunction

    // A single-cycle lockout still needs a one-bit counter.
    function automatic int unsigned lockout_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned DEF_ATT_CNT_W = att_cnt_w(DEF_MAX_ATTEMPTS);
    localparam int unsigned DEF_LO_CNT_W  = lockout_cnt_w(DEF_LOCKOUT_CYCLES);

endpackage

// File: rtl/reglk_unlock_fsm.sv
// JTAG key unlock state machine with attempt counting and timed lockout.
module reglk_unlock_fsm
    import reglk_pkg::*;
#(
    parameter int unsigned KEY_W          = 32,
    parameter int unsigned MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic             clk_i,
    input  logic             rst_low,
    input  logic             req,
    input  logic [KEY_W-1:0] key,
    input  logic             relock,
    input  logic [KEY_W-1:0] fuse_key,
    output logic             unlocked,
    output logic             lockout,
    output logic             ack,
    output logic             fail
);

    localparam int unsigned ATT_W = att_cnt_w(MAX_ATTEMPTS);
    localparam int unsigned LO_W  = lockout_cnt_w(LOCKOUT_CYCLES);

    reglk_state_e     state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [ATT_W-1:0] att_q, att_d;
    logic [LO_W-1:0]  lo_q, lo_d;
    logic             ack_d, fail_d;

    always_ff @(posedge clk_i or negedge rst_low) begin
        if (!rst_low) begin
            state_q  <= ST_LOCKED;
            key_q    <= '0;
            att_q    <= '0;
            lo_q     <= '0;
            ack      <= 1'b0;
            fail     <= 1'b0;
            unlocked <= 1'b0;
            lockout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            att_q    <= att_d;
            lo_q     <= lo_d;
            ack      <= ack_d;
            fail     <= fail_d;
            unlocked <= (state_d == ST_UNLOCKED);
            lockout  <= (state_d == ST_LOCKOUT);
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        att_d   = att_q;
        lo_d    = lo_q;
        ack_d   = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                if (req) begin
                    key_d   = key;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (key_q == fuse_key) begin
                    state_d = ST_UNLOCKED;
                    ack_d   = 1'b1;
                    att_d   = '0;
                end else begin
                    att_d  = att_q + ATT_W'(1);
                    fail_d = 1'b1;
                    if (att_d == ATT_W'(MAX_ATTEMPTS)) begin
                        state_d = ST_LOCKOUT;
                        lo_d    = LO_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (relock) state_d = ST_LOCKED;
            end
            ST_LOCKOUT: begin
                if (lo_q == '0) begin
                    state_d = ST_LOCKED;
                    att_d   = '0;
                end else begin
                    lo_d = lo_q - LO_W'(1);
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

endmodule

// File: rtl/reglk_ctrl.sv
// Register-lock controller: lock-word array with set-only writes unless unlocked via JTAG key.
module reglk_ctrl
    import reglk_pkg::*;
#(
    parameter int unsigned         NUM_REGS       = 6,
    parameter int unsigned         DATA_W         = DEF_DATA_W,
    parameter int unsigned         KEY_W          = 32,
    parameter int unsigned         MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int unsigned         LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter logic [DATA_W-1:0]   RST_VAL        = '1
) (
    input  logic                              clk_i,
    input  logic                              rst_low,
    input  logic                              wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0]       wr_idx_i,
    input  logic [DATA_W-1:0]                 wr_data_i,
    output logic                              wr_err_o,
    input  logic                              rst_reg_lck_i,
    input  logic                              jtag_req_i,
    input  logic [KEY_W-1:0]                  jtag_key_i,
    input  logic                              jtag_relock_i,
    input  logic [KEY_W-1:0]                  fuse_key_i,
    output logic                              jtag_ack_o,
    output logic                              jtag_fail_o,
    output logic                              unlocked_o,
    output logic                              lockout_o,
    output logic                              viol_o,
    output logic [NUM_REGS-1:0][DATA_W-1:0]   reglk_mem_o
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
    logic                            err_d, viol_d;

    reglk_unlock_fsm #(
        .KEY_W          (KEY_W),
        .MAX_ATTEMPTS   (MAX_ATTEMPTS),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_fsm (
        .clk_i    (clk_i),
        .rst_low  (rst_low),
        .req      (jtag_req_i),
        .key      (jtag_key_i),
        .relock   (jtag_relock_i),
        .fuse_key (fuse_key_i),
        .unlocked (unlocked_o),
        .lockout  (lockout_o),
        .ack      (jtag_ack_o),
        .fail     (jtag_fail_o)
    );

    always_ff @(posedge clk_i or negedge rst_low) begin
        if (!rst_low) begin
            mem_q    <= {NUM_REGS{RST_VAL}};
            wr_err_o <= 1'b0;
            viol_o   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_err_o <= err_d;
            viol_o   <= viol_d;
        end
    end

    // unlocked_o mirrors the current state, so writes alongside relock still replace.
    always_comb begin
        mem_d  = mem_q;
        err_d  = 1'b0;
        viol_d = viol_o;
        if (rst_reg_lck_i && unlocked_o) begin
            mem_d = '0;
        end else begin
            if (rst_reg_lck_i) viol_d = 1'b1;
            if (wr_en_i) begin
                if (32'(wr_idx_i) >= NUM_REGS) begin
                    err_d = 1'b1;
                end else if (unlocked_o) begin
                    mem_d[wr_idx_i] = wr_data_i;
                end else begin
                    mem_d[wr_idx_i] = mem_q[wr_idx_i] | wr_data_i;
                    if ((mem_q[wr_idx_i] & ~wr_data_i) != '0) begin
                        err_d  = 1'b1;
                        viol_d = 1'b1;
                    end
                end
            end
        end
    end

    assign reglk_mem_o = mem_q;

endmodule

// File: tb/tb_reglk_ctrl.sv
// Randomised and directed bench for reglk_ctrl against a cycle-level behavioural model.
module tb_reglk_ctrl;

    localparam int NR = 6;
    localparam int DW = 32;
    localparam int KW = 32;
    localparam int MAXA = 3;
    localparam int LOC = 1024;
    localparam logic [KW-1:0] FUSE = 32'hC0DE_1234;

    logic                  clk_i = 1'b0;
    logic                  rst_low;
    logic                  wr_en_i;
    logic [2:0]            wr_idx_i;
    logic [DW-1:0]         wr_data_i;
    logic                  wr_err_o;
    logic                  rst_reg_lck_i;
    logic                  jtag_req_i;
    logic [KW-1:0]         jtag_key_i;
    logic                  jtag_relock_i;
    logic [KW-1:0]         fuse_key_i;
    logic                  jtag_ack_o, jtag_fail_o, unlocked_o, lockout_o, viol_o;
    logic [NR-1:0][DW-1:0] reglk_mem_o;

    reglk_ctrl dut (
        .clk_i(clk_i), .rst_low(rst_low), .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i),
        .wr_data_i(wr_data_i), .wr_err_o(wr_err_o), .rst_reg_lck_i(rst_reg_lck_i),
        .jtag_req_i(jtag_req_i), .jtag_key_i(jtag_key_i), .jtag_relock_i(jtag_relock_i),
        .fuse_key_i(fuse_key_i), .jtag_ack_o(jtag_ack_o), .jtag_fail_o(jtag_fail_o),
        .unlocked_o(unlocked_o), .lockout_o(lockout_o), .viol_o(viol_o),
        .reglk_mem_o(reglk_mem_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: mode 0 locked, 1 checking, 2 unlocked, 3 locked out.
    int                    m_mode, m_fails, cyc, lo_end;
    logic [KW-1:0]         m_key;
    logic [NR-1:0][DW-1:0] m_mem;
    bit                    m_viol, m_err, m_ack, m_fail;

    always @(posedge clk_i) begin
        cyc++;
        if (!rst_low) begin
            m_mode = 0; m_fails = 0; m_viol = 0; m_err = 0; m_ack = 0; m_fail = 0;
            m_mem = '1;
        end else begin
            m_err = 0; m_ack = 0; m_fail = 0;
            if (rst_reg_lck_i && m_mode == 2) begin
                m_mem = '0;
            end else begin
                if (rst_reg_lck_i) m_viol = 1;
                if (wr_en_i) begin
                    if (int'(wr_idx_i) >= NR) m_err = 1;
                    else if (m_mode == 2) m_mem[wr_idx_i] = wr_data_i;
                    else begin
                        if ((m_mem[wr_idx_i] & ~wr_data_i) != 0) begin m_viol = 1; m_err = 1; end
                        m_mem[wr_idx_i] = m_mem[wr_idx_i] | wr_data_i;
                    end
                end
            end
            case (m_mode)
                0: if (jtag_req_i) begin m_key = jtag_key_i; m_mode = 1; end
                1: begin
                    if (m_key == fuse_key_i) begin m_mode = 2; m_ack = 1; m_fails = 0; end
                    else begin
                        m_fails++; m_fail = 1;
                        if (m_fails == MAXA) begin m_mode = 3; lo_end = cyc + LOC; end
                        else m_mode = 0;
                    end
                end
                2: if (jtag_relock_i) m_mode = 0;
                default: if (cyc == lo_end) begin m_mode = 0; m_fails = 0; end
            endcase
        end
    end

    always begin
        @(posedge clk_i); #1;
        check("mem",      192'(reglk_mem_o), 192'(m_mem));
        check("wr_err",   192'(wr_err_o),    192'(m_err));
        check("viol",     192'(viol_o),      192'(m_viol));
        check("ack",      192'(jtag_ack_o),  192'(m_ack));
        check("fail",     192'(jtag_fail_o), 192'(m_fail));
        check("unlocked", 192'(unlocked_o),  192'(m_mode == 2));
        check("lockout",  192'(lockout_o),   192'(m_mode == 3));
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk_i); #2; end
    endtask

    task automatic idle();
        wr_en_i = 0; wr_idx_i = '0; wr_data_i = '0; rst_reg_lck_i = 0;
        jtag_req_i = 0; jtag_key_i = '0; jtag_relock_i = 0;
    endtask

    task automatic do_reset();
        rst_low = 0; step(2); rst_low = 1; step(1);
    endtask

    task automatic try_key(input logic [KW-1:0] k);
        jtag_req_i = 1; jtag_key_i = k; step(1);
        jtag_req_i = 0; step(1);
    endtask

    logic [NR-1:0][DW-1:0] all_ones;
    int lo_cnt;

    initial begin
        cyc = 0; lo_end = -1;
        all_ones = '1;
        fuse_key_i = FUSE;
        idle();
        rst_low = 0;
        step(2);
        check("rst_mem", 192'(reglk_mem_o), 192'(all_ones));
        check("rst_viol", 192'(viol_o), 192'(0));
        rst_low = 1; step(1);

        // clearing write while locked
        wr_en_i = 1; wr_idx_i = 3'd2; wr_data_i = 32'h0; step(1); idle();
        check("lk_mem2", 192'(reglk_mem_o[2]), 192'(32'hFFFF_FFFF));
        check("lk_err", 192'(wr_err_o), 192'(1));
        check("lk_viol", 192'(viol_o), 192'(1));

        // correct key unlock, ack on second edge
        try_key(FUSE);
        check("unl_ack", 192'(jtag_ack_o), 192'(1));
        check("unl_state", 192'(unlocked_o), 192'(1));
        wr_en_i = 1; wr_idx_i = 3'd0; wr_data_i = 32'h0000_00F0; step(1); idle();
        check("unl_ack_gone", 192'(jtag_ack_o), 192'(0));
        check("unl_mem0", 192'(reglk_mem_o[0]), 192'(32'h0000_00F0));
        rst_reg_lck_i = 1; step(1); idle();
        check("clr_all", 192'(reglk_mem_o), 192'(0));
        wr_en_i = 1; wr_idx_i = 3'd1; wr_data_i = 32'hFF; step(1); idle();
        rst_reg_lck_i = 1; wr_en_i = 1; wr_idx_i = 3'd1; wr_data_i = 32'hA5; step(1); idle();
        check("clr_beats_wr", 192'(reglk_mem_o), 192'(0));

        // out-of-range write and clear attempt while locked
        do_reset();
        wr_en_i = 1; wr_idx_i = 3'd7; wr_data_i = 32'h0; step(1); idle();
        check("oor_mem", 192'(reglk_mem_o), 192'(all_ones));
        check("oor_err", 192'(wr_err_o), 192'(1));
        check("oor_viol", 192'(viol_o), 192'(0));
        try_key(FUSE);
        jtag_relock_i = 1; step(1); idle();
        check("relock", 192'(unlocked_o), 192'(0));
        rst_reg_lck_i = 1; step(1); idle();
        check("lk_clr_viol", 192'(viol_o), 192'(1));
        check("lk_clr_mem", 192'(reglk_mem_o), 192'(all_ones));

        // three wrong keys then lockout
        for (int i = 0; i < MAXA; i++) begin
            try_key(FUSE ^ 32'h1);
            check("bad_fail", 192'(jtag_fail_o), 192'(1));
            if (i < MAXA - 1) step(1);
        end
        check("lo_enter", 192'(lockout_o), 192'(1));
        lo_cnt = 1;
        for (int i = 0; i < 1100 && lockout_o; i++) begin
            jtag_req_i = (i % 100 == 50); jtag_key_i = FUSE;
            step(1);
            if (lockout_o) lo_cnt++;
        end
        idle();
        check("lo_len", 192'(lo_cnt), 192'(LOC));
        try_key(FUSE);
        check("post_lo_ack", 192'(jtag_ack_o), 192'(1));

        // reset while checking
        do_reset();
        wr_en_i = 1; wr_idx_i = 3'd4; wr_data_i = 32'h0; step(1); idle();
        jtag_req_i = 1; jtag_key_i = FUSE; step(1); idle();
        rst_low = 0; #1;
        check("rchk_mem", 192'(reglk_mem_o), 192'(all_ones));
        check("rchk_viol", 192'(viol_o), 192'(0));
        step(1);
        check("rchk_ack", 192'(jtag_ack_o), 192'(0));
        rst_low = 1; step(1);
        check("rchk_unl", 192'(unlocked_o), 192'(0));
        check("rchk_ack2", 192'(jtag_ack_o), 192'(0));

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            wr_en_i = ($urandom_range(9, 0) < 3);
            wr_idx_i = 3'($urandom_range(7, 0));
            case ($urandom_range(3, 0))
                0: wr_data_i = '0;
                1: wr_data_i = '1;
                default: wr_data_i = $urandom;
            endcase
            rst_reg_lck_i = ($urandom_range(19, 0) == 0);
            jtag_req_i = ($urandom_range(9, 0) == 0);
            jtag_key_i = ($urandom_range(9, 0) < 4) ? FUSE : KW'($urandom);
            jtag_relock_i = ($urandom_range(19, 0) == 0);
            rst_low = ($urandom_range(399, 0) != 0);
            step(1);
        end
        idle(); rst_low = 1; step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
